spi_burst_memory: RTL
=====================

// Module: spi_burst_memory
// PURPOSE
//  Parametrised SPI-slave memory: next generation of the single-byte SPI memory block.
//  Adds configurable data/address width, all four SPI modes and multi-word bursts
//  within one chip-select frame. Sits between the FPGA SPI pins and on-chip RAM;
//  the whole block runs on clk.
// PARAMETERS
//  DATA_W       8            data word width, bits
//  ADDR_W       7            address width, bits; DEPTH = 2**ADDR_W words
//  CPOL         0            sclk idle level
//  CPHA         0            0: sample on leading edge; 1: sample on trailing edge
//  SYNC_STAGES  2            synchroniser flops on sclk/cs/mosi (min 2)
// PORTS
//  clk        in   1       system clock; all logic is clocked on its rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  sclk_pin   in   1       SPI clock, asynchronous to clk
//  cs_pin     in   1       SPI chip select, active low
//  mosi_pin   in   1       master-out serial data, MSB first
//  miso_pin   out  1       master-in serial data, MSB first
//  miso_oe    out  1       tristate enable for miso pad, 1 = drive
//  busy       out  1       1 while a frame is active (cs low, synchronised)
//  cur_addr   out  ADDR_W  current word address, for debug
// BEHAVIOUR
//  - Reset values: miso_pin=0, miso_oe=0, busy=0, cur_addr=0, FSM=IDLE. RAM is not reset.
//  - Sync and edges: every pin passes SYNC_STAGES flops; sample/shift edges are
//    detected in the clk domain. Pin-to-action latency is SYNC_STAGES+1 clk.
//    Requirement: each sclk phase is at least SYNC_STAGES+4 clk cycles.
//  - Frame format: a header of ADDR_W address bits (MSB first), then 1 R/W bit
//    (1 = read), then N >= 1 data words of DATA_W bits each.
//  - FSM states: IDLE, HDR, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_STORE.
//    IDLE -cs low-> HDR. After ADDR_W+1 samples: R/W=1 -> RD_LOAD, R/W=0 -> WR_SHIFT.
//  - RD_LOAD: read RAM[addr] (1 clk latency), load the shift register, go to RD_SHIFT.
//    miso_oe rises in RD_LOAD. The MSB appears on the first shift edge after the last
//    header sample; for CPHA=0 it is driven immediately. One bit per shift edge.
//  - WR_SHIFT: after DATA_W samples go to WR_STORE. WR_STORE writes the word in 1 clk,
//    then returns to WR_SHIFT.
//  - Word boundary: with SPI_MEM_AUTOINC_EN, addr = addr+1 mod DEPTH (DEPTH-1 wraps
//    to 0). Without it, addr is held. Reads then reload via RD_LOAD.
//  - cs rising at any point, including mid-header or mid-word: go to IDLE next clk,
//    miso_oe=0, busy=0, a partial write word is discarded (no RAM write), partial
//    header ignored.
//  - cs rise on the same clk as a WR_STORE: the store completes (word already full).
//  - reset_n low mid-frame: immediate return to reset values. The frame is lost;
//    the master must re-raise cs.
// CONFIGURATION
//  SPI_MEM_AUTOINC_EN defined: burst address auto-increments each word, wrapping.
//  Not defined: every word in the frame targets the header address (repeat read /
//  overwrite). cur_addr is then constant per frame.
// STRUCTURE
//  Package spi_mem_pkg: FSM state typedef, CPOL/CPHA-derived edge-select constants,
//  and the R/W bit encoding constants.
//  Sub-module spi_edge_sync: synchroniser + rise/fall detect, one instance per pin.
//  Shift register, address counter and RAM are inline.
// TESTING
//  1. Mode 0, write header addr=0x05 W, data 0xA5, cs high; then read addr=0x05
//     -> miso returns 0xA5.
//  2. AUTOINC, write burst at 0x7E with 0x11,0x22,0x33 -> RAM[0x7E]=0x11,
//     RAM[0x7F]=0x22, RAM[0x00]=0x33. A read burst returns the same order.
//  3. Modes 1/2/3 each: write 0x3C at 0x10, read back -> 0x3C; miso changes only on
//     shift edges.
//  4. cs raised after 5 bits of a write word at 0x20 (RAM[0x20]=0x99 beforehand)
//     -> RAM[0x20] stays 0x99; miso_oe=0 and busy=0 within SYNC_STAGES+2 clk.
//  5. AUTOINC undefined, write burst 0x01,0x02 at 0x40 -> RAM[0x40]=0x02, 0x41 untouched.
//  6. reset_n pulsed low mid-read -> miso_oe=0, busy=0 immediately; next frame works.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI burst memory.
//   spi_state_e     : frame FSM states
//   RW_READ/WRITE   : encoding of the R/W bit that ends the header
//   sample_on_rise(): maps an SPI mode (CPOL, CPHA) to the sclk edge used for sampling;
//                     the opposite edge is the shift (drive) edge.
package spi_mem_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StRdLoad,
      StRdShift,
      StWrShift,
      StWrStore
   } spi_state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // Modes 0 and 3 sample on the rising sclk edge; modes 1 and 2 on the falling edge.
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return cpol == cpha;
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser with rise/fall detection for one asynchronous pin.
// Ports:
//   clk_i, rst_ni : system clock, asynchronous active-low reset
//   async_i       : raw pin
//   level_o       : synchronised level (SyncStages clk after the pin)
//   rise_o/fall_o : single-clk pulses on a synchronised 0->1 / 1->0 transition
module spi_edge_sync #(
   parameter int unsigned SyncStages = 2,
   parameter bit          ResetVal   = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SyncStages-1:0] sync_q, sync_d;
   logic                  prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SyncStages-2:0], async_i};
      prev_d = sync_q[SyncStages-1];
   end

   // Reset to the pin's idle level so no spurious edge is seen after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {SyncStages{ResetVal}};
         prev_q <= ResetVal;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level_o = sync_q[SyncStages-1];
   assign rise_o  = sync_q[SyncStages-1] & ~prev_q;
   assign fall_o  = ~sync_q[SyncStages-1] & prev_q;

endmodule

// File: rtl/spi_burst_memory.sv
// SPI-slave memory with burst access, all four SPI modes, everything on clk.
// Frame: ADDR_W address bits (MSB first), one R/W bit (1 = read), then N data words.
// Optional feature macro SPI_MEM_AUTOINC_EN: when defined the word address increments
// (wrapping) after every word of a burst; otherwise every word uses the header address.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   sclk_pin     : SPI clock (asynchronous)
//   cs_pin       : chip select, active low
//   mosi_pin     : serial data in, MSB first
//   miso_pin     : serial data out, MSB first
//   miso_oe      : miso pad drive enable
//   busy         : frame in progress
//   cur_addr     : current word address (debug)
module spi_burst_memory
   import spi_mem_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 7,
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sclk_pin,
   input  logic              cs_pin,
   input  logic              mosi_pin,
   output logic              miso_pin,
   output logic              miso_oe,
   output logic              busy,
   output logic [ADDR_W-1:0] cur_addr
);

`ifdef SPI_MEM_AUTOINC_EN
   localparam bit AutoInc = 1'b1;
`else
   localparam bit AutoInc = 1'b0;
`endif

   localparam int unsigned Depth      = 2 ** ADDR_W;
   localparam int unsigned MaxW       = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int unsigned CntW       = $clog2(MaxW + 1);
   localparam logic        SampleRise = sample_on_rise(CPOL, CPHA);

   // Synchronised pins and edges
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   spi_edge_sync #(
      .SyncStages (SYNC_STAGES),
      .ResetVal   (CPOL)
   ) u_sync_sclk (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .async_i (sclk_pin),
      .level_o (sclk_lvl),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   spi_edge_sync #(
      .SyncStages (SYNC_STAGES),
      .ResetVal   (1'b1)
   ) u_sync_cs (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .async_i (cs_pin),
      .level_o (cs_lvl),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   spi_edge_sync #(
      .SyncStages (SYNC_STAGES),
      .ResetVal   (1'b0)
   ) u_sync_mosi (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .async_i (mosi_pin),
      .level_o (mosi_lvl),
      .rise_o  (mosi_rise),
      .fall_o  (mosi_fall)
   );

   // Only levels of cs/mosi and the edges of sclk drive the FSM.
   logic unused_sync;
   assign unused_sync = ^{sclk_lvl, cs_rise, cs_fall, mosi_rise, mosi_fall};

   logic sample_evt, shift_evt;
   assign sample_evt = SampleRise ? sclk_rise : sclk_fall;
   assign shift_evt  = SampleRise ? sclk_fall : sclk_rise;

   // State
   spi_state_e        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] hdr_q, hdr_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              miso_q, miso_d;
   logic              oe_q, oe_d;
   logic              busy_q, busy_d;

   logic [DATA_W-1:0] mem [Depth];
   logic [DATA_W-1:0] rd_data_q;
   logic [ADDR_W-1:0] addr_next;

   assign addr_next = AutoInc ? addr_q + ADDR_W'(1) : addr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hdr_d   = hdr_q;
      sh_d    = sh_q;
      addr_d  = addr_q;
      miso_d  = miso_q;
      oe_d    = oe_q;

      unique case (state_q)
         StIdle: begin
            miso_d = 1'b0;
            oe_d   = 1'b0;
            if (!cs_lvl) begin
               state_d = StHdr;
               cnt_d   = '0;
               hdr_d   = '0;
            end
         end
         StHdr: begin
            if (sample_evt) begin
               // The sample after ADDR_W address bits is the R/W bit.
               if (cnt_q == CntW'(ADDR_W)) begin
                  addr_d  = hdr_q;
                  cnt_d   = '0;
                  state_d = (mosi_lvl == RW_READ) ? StRdLoad : StWrShift;
               end else begin
                  hdr_d = {hdr_q[ADDR_W-2:0], mosi_lvl};
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StRdLoad: begin
            // rd_data_q was fetched from addr_d on the transition into this state.
            sh_d    = rd_data_q;
            cnt_d   = '0;
            oe_d    = 1'b1;
            state_d = StRdShift;
         end
         StRdShift: begin
            if (shift_evt) begin
               miso_d = sh_q[DATA_W-1];
               sh_d   = {sh_q[DATA_W-2:0], 1'b0};
               if (cnt_q == CntW'(DATA_W - 1)) begin
                  addr_d  = addr_next;
                  cnt_d   = '0;
                  state_d = StRdLoad;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StWrShift: begin
            if (sample_evt) begin
               sh_d = {sh_q[DATA_W-2:0], mosi_lvl};
               if (cnt_q == CntW'(DATA_W - 1)) begin
                  cnt_d   = '0;
                  state_d = StWrStore;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StWrStore: begin
            addr_d  = addr_next;
            state_d = StWrShift;
         end
         default: state_d = StIdle;
      endcase

      // Frame end overrides everything; a full word in StWrStore is still written
      // because the RAM write is keyed on state_q alone.
      if (cs_lvl && (state_q != StIdle)) begin
         state_d = StIdle;
         oe_d    = 1'b0;
         miso_d  = 1'b0;
         if (state_q != StWrStore) begin
            addr_d = addr_q;
         end
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hdr_q   <= '0;
         sh_q    <= '0;
         addr_q  <= '0;
         miso_q  <= 1'b0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         sh_q    <= sh_d;
         addr_q  <= addr_d;
         miso_q  <= miso_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
      end
   end

   // RAM: not reset; synchronous read addressed by the next address so the
   // word is ready in StRdLoad.
   always_ff @(posedge clk) begin
      if (state_q == StWrStore) begin
         mem[addr_q] <= sh_q;
      end
      rd_data_q <= mem[addr_d];
   end

   assign miso_pin = miso_q;
   assign miso_oe  = oe_q;
   assign busy     = busy_q;
   assign cur_addr = addr_q;

endmodule
